// File: rtl/booth_mac_accumulator_if.sv
// booth_mac_accumulator_if: product input, result output and clear for the Booth MAC accumulator
interface booth_mac_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;
  modport slave (
    input  clear, in_valid, product, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
  modport master (
    output clear, in_valid, product, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator: sums LEN signed Booth products into an ACC_W dot product with sticky overflow flag.
// Define BOOTH_MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module booth_mac_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN    = 4
) (
  input logic CLK,
  input logic RST,
  booth_mac_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(LEN) + 1;
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic signed [ACC_W-1:0] acc, ext, add, acc_nx;
  logic [CNT_W-1:0] cnt;
  logic ovf, add_ovf, take, last;
  logic [ACC_W-1:0] sum_q;
  logic ovf_q;
  always_comb begin
    ext     = ACC_W'(signed'(bus.product[PROD_W-1:0]));
    add     = acc + ext;
    add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (add[ACC_W-1] != acc[ACC_W-1]);
`ifdef BOOTH_MAC_SATURATE_EN
    acc_nx  = add_ovf ? (ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) : add;
`else
    acc_nx  = add;
`endif
    take     = state == ACCUM && bus.in_valid;
    last     = cnt == CNT_W'(LEN - 1);
    state_nx = bus.clear ? ACCUM :
               take && last ? HOLD :
               state == HOLD && bus.out_ready ? ACCUM : state;
  end
  always_ff @(posedge CLK)
    state <= RST ? ACCUM : state_nx;
  // a handshaken result and clear both restart the dot product from zero
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (bus.clear || (state == HOLD && bus.out_ready)) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (take) begin
      acc <= acc_nx;
      cnt <= cnt + CNT_W'(1);
      ovf <= ovf | add_ovf;
      if (last) begin
        sum_q <= acc_nx;
        ovf_q <= ovf | add_ovf;
      end
    end
  end
  assign bus.in_ready  = state == ACCUM;
  assign bus.out_valid = state == HOLD;
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_booth_mac_accumulator.sv
// tb_booth_mac_accumulator: directed table plus corner sequences for default, ACC_W=16 and LEN=1 builds
module tb_booth_mac_accumulator;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  booth_mac_accumulator_if #(.PROD_W(16), .ACC_W(24)) a_if ();
  booth_mac_accumulator_if #(.PROD_W(16), .ACC_W(16)) b_if ();
  booth_mac_accumulator_if #(.PROD_W(16), .ACC_W(24)) c_if ();
  booth_mac_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(4)) u_a (.CLK(CLK), .RST(RST), .bus(a_if.slave));
  booth_mac_accumulator #(.PROD_W(16), .ACC_W(16), .LEN(4)) u_b (.CLK(CLK), .RST(RST), .bus(b_if.slave));
  booth_mac_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(1)) u_c (.CLK(CLK), .RST(RST), .bus(c_if.slave));
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic rst, clr, v, ordy;
    logic [15:0] p;
    logic e_rdy, e_val, chk;
    logic [23:0] e_sum;
    logic e_ovf;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  function automatic void push(logic rst, logic clr, logic v, logic ordy, logic [15:0] p,
                               logic e_rdy, logic e_val, logic c, logic [23:0] e_sum, logic e_ovf);
    tbl.push_back(vec_t'{rst, clr, v, ordy, p, e_rdy, e_val, c, e_sum, e_ovf});
  endfunction
  function automatic void acc_v(logic [15:0] p);
    push(0, 0, 1, 0, p, 1, 0, 0, 24'h0, 0);
  endfunction
  function automatic void idle();
    push(0, 0, 0, 0, 16'h0, 1, 0, 0, 24'h0, 0);
  endfunction
  function automatic void res(logic [23:0] s, logic o, logic ordy, logic v);
    push(0, 0, v, ordy, 16'h1234, 0, 1, 1, s, o);
  endfunction
  initial begin
    {a_if.clear, a_if.in_valid, a_if.out_ready, a_if.product} = '0;
    {b_if.clear, b_if.in_valid, b_if.out_ready, b_if.product} = '0;
    {c_if.clear, c_if.in_valid, c_if.out_ready, c_if.product} = '0;
    tick;
    tick;
    RST = 1'b0;
    chk("rst a rdy", a_if.in_ready, 1);
    chk("rst a val", a_if.out_valid, 0);
    chk("rst a sum", a_if.out_sum, 0);
    chk("rst a ovf", a_if.out_ovf, 0);
    chk("rst b rdy", b_if.in_ready, 1);
    chk("rst c val", c_if.out_valid, 0);
    // basic dot product, released immediately
    acc_v(16'hEE56); acc_v(16'h0736); acc_v(16'h0CD6); acc_v(16'h1E06);
    res(24'h002068, 0, 1, 0);
    idle();
    // bubbles, five cycles of backpressure with ignored products, then a fresh sum
    acc_v(16'hEE56); idle(); acc_v(16'h0736); idle(); idle();
    acc_v(16'h0CD6); idle(); idle(); idle(); acc_v(16'h1E06);
    for (int k = 0; k < 5; k++) res(24'h002068, 0, 0, 1);
    res(24'h002068, 0, 1, 1);
    acc_v(16'd1); acc_v(16'd2); acc_v(16'd3); acc_v(16'd4);
    res(24'h00000A, 0, 1, 0);
    // reset mid-operation
    acc_v(16'd5); acc_v(16'd3);
    push(1, 0, 0, 0, 16'h0, 1, 0, 0, 24'h0, 0);
    push(0, 0, 0, 0, 16'h0, 1, 0, 1, 24'h0, 0);
    acc_v(16'd10); acc_v(16'd20); acc_v(16'd30); acc_v(16'd40);
    res(24'h000064, 0, 1, 0);
    // clear in HOLD, then clear with a product on the third beat
    acc_v(16'd5); acc_v(16'd5); acc_v(16'd5); acc_v(16'd5);
    res(24'h000014, 0, 0, 0);
    push(0, 1, 0, 0, 16'h0, 0, 1, 1, 24'h000014, 0);
    acc_v(16'hFFFF); acc_v(16'hFFFF);
    push(0, 1, 1, 0, 16'hFFFF, 1, 0, 0, 24'h0, 0);
    acc_v(16'hFFFF); acc_v(16'hFFFF); acc_v(16'hFFFF); acc_v(16'hFFFF);
    res(24'hFFFFFC, 0, 1, 0);
    idle();
    foreach (tbl[i]) begin
      RST = tbl[i].rst;
      a_if.clear = tbl[i].clr;
      a_if.in_valid = tbl[i].v;
      a_if.out_ready = tbl[i].ordy;
      a_if.product = tbl[i].p;
      chk($sformatf("vec%0d rdy", i), a_if.in_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d val", i), a_if.out_valid, tbl[i].e_val);
      if (tbl[i].chk) begin
        chk($sformatf("vec%0d sum", i), a_if.out_sum, tbl[i].e_sum);
        chk($sformatf("vec%0d ovf", i), a_if.out_ovf, tbl[i].e_ovf);
      end
      tick;
    end
    RST = 1'b0;
    a_if.in_valid = 1'b0;
    a_if.clear = 1'b0;
    // ACC_W=16 overflow: wraps to 0 or saturates at 0x7FFF
    b_if.in_valid = 1'b1;
    b_if.product = 16'h4000;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf beat%0d rdy", k), b_if.in_ready, 1);
      tick;
    end
    b_if.in_valid = 1'b0;
    chk("ovf val", b_if.out_valid, 1);
`ifdef BOOTH_MAC_SATURATE_EN
    chk("ovf sum", b_if.out_sum, 32'h7FFF);
`else
    chk("ovf sum", b_if.out_sum, 32'h0000);
`endif
    chk("ovf flag", b_if.out_ovf, 1);
    b_if.out_ready = 1'b1;
    tick;
    b_if.out_ready = 1'b0;
    b_if.in_valid = 1'b1;
    b_if.product = 16'd1;
    repeat (4) tick;
    b_if.in_valid = 1'b0;
    chk("post ovf val", b_if.out_valid, 1);
    chk("post ovf sum", b_if.out_sum, 32'h0004);
    chk("post ovf flag", b_if.out_ovf, 0);
    b_if.out_ready = 1'b1;
    tick;
    chk("post ovf drop", b_if.out_valid, 0);
    b_if.out_ready = 1'b0;
    // LEN=1: every accept completes, one bubble between accepts
    c_if.in_valid = 1'b1;
    c_if.product = 16'h8000;
    chk("len1 rdy0", c_if.in_ready, 1);
    tick;
    c_if.product = 16'h7FFF;
    chk("len1 val0", c_if.out_valid, 1);
    chk("len1 busy", c_if.in_ready, 0);
    chk("len1 sum0", c_if.out_sum, 32'hFF8000);
    chk("len1 ovf0", c_if.out_ovf, 0);
    c_if.out_ready = 1'b1;
    tick;
    c_if.out_ready = 1'b0;
    chk("len1 gap val", c_if.out_valid, 0);
    chk("len1 gap rdy", c_if.in_ready, 1);
    tick;
    c_if.in_valid = 1'b0;
    chk("len1 val1", c_if.out_valid, 1);
    chk("len1 sum1", c_if.out_sum, 32'h007FFF);
    chk("len1 ovf1", c_if.out_ovf, 0);
    c_if.out_ready = 1'b1;
    tick;
    chk("len1 done", c_if.out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/booth_mac_accumulator.md
Name: booth_mac_accumulator

Overview:
- Downstream consumer of the 8x8 signed radix-8 Booth multiplier top level.
- Accepts the 16-bit signed products one per cycle under a valid/ready handshake and accumulates LEN of them into a wider signed sum (dot product).
- Presents each completed sum with an overflow flag on a registered valid/ready output port.

Parameters:
PROD_W, 16, product width; signed two's complement; matches multiplier final_result
ACC_W, 24, accumulator and out_sum width; must be >= PROD_W
LEN, 4, products per dot product; must be >= 1

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
clear  input  1  synchronous abort of the current dot product
in_valid  input  1  product is valid this cycle
in_ready  output  1  block can accept a product this cycle
product  input  PROD_W  signed product from the multiplier
out_valid  output  1  out_sum/out_ovf hold a completed dot product
out_ready  input  1  downstream accepts the result
out_sum  output  ACC_W  signed accumulated sum
out_ovf  output  1  signed overflow occurred during this dot product

Behaviour:
- Reset (RST high at an edge): state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0. in_ready is 1 in the first cycle after reset. RST overrides all other inputs; reset mid-operation discards partial sums.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- ACCUM transfer (in_valid & in_ready):
  - acc <= acc + sign_extend(product), cnt <= cnt+1.
  - Cycles with in_valid=0 are bubbles: no change.
- Completion: transfer with cnt==LEN-1:
  - out_sum <= the new sum, out_ovf <= ovf OR overflow of this add, state <= HOLD.
  - out_valid rises the cycle after the LEN-th accepted product (latency 1).
- HOLD:
  - out_sum/out_ovf are stable while out_ready=0.
  - Products presented are not accepted because in_ready=0.
  - On out_ready=1: out_valid<=0, acc<=0, cnt<=0, ovf<=0, state<=ACCUM.
  - No same-cycle output-accept/input-accept overlap; one bubble per dot product.
- clear (priority below RST, above everything else):
  - acc=0, cnt=0, ovf=0, out_valid=0, state=ACCUM.
  - A product presented in the clear cycle is dropped.
  - A result pending in HOLD is discarded.
  - out_sum keeps its old value but is meaningless while out_valid=0.
- Overflow detection: the add overflows when both operands have the same sign and the ACC_W-bit result sign differs. The ovf flag is sticky within one dot product.
- LEN=1: every accepted product goes directly to HOLD.
- Width: cnt width is clog2(LEN)+1 bits; no wrap is possible because cnt resets on completion.

Optional Feature:
- Macro: BOOTH_MAC_SATURATE_EN.
- Defined: on overflow, acc clamps to the signed max (2^(ACC_W-1)-1) or min (-2^(ACC_W-1)) according to the operand sign, and later adds continue from the clamped value. out_ovf is flagged as usual.
- Undefined: two's-complement wrap-around, with out_ovf still flagged.
- Identical behaviour when no overflow occurs.

Test Plan:
1. Basic sum, defaults, out_ready=1:
   - Stimulus: products 0xEE56 (-4522), 0x0736 (1846), 0x0CD6 (3286), 0x1E06 (7686) on consecutive cycles.
   - Required: out_valid high for 1 cycle, 1 cycle after the 4th product; out_sum=0x002068 (8296), out_ovf=0; in_ready low for that cycle.
2. Bubbles and backpressure:
   - Stimulus: same four products with in_valid gaps of 0-3 cycles; out_ready held low 5 cycles.
   - Required: out_sum=0x002068 held stable with out_valid=1 for all 5 cycles. Products presented during HOLD are ignored. The next dot product starts from 0 after out_ready.
3. Overflow, ACC_W=16:
   - Stimulus: four products of 0x4000.
   - Required without macro: out_sum=0x0000, out_ovf=1.
   - Required with BOOTH_MAC_SATURATE_EN: out_sum=0x7FFF, out_ovf=1.
   - Required after that: the next dot product 1,1,1,1 gives 0x0004, out_ovf=0.
4. Reset mid-operation:
   - Stimulus: 2 products accepted (0x0005, 0x0003), RST high one cycle, then 10,20,30,40.
   - Required: after reset all outputs are 0 and in_ready=1; the result is out_sum=100 (0x000064), out_ovf=0.
5. clear during HOLD and during ACCUM:
   - Required, clear in HOLD: out_valid drops the next cycle and the result is never handshaken.
   - Required, clear with in_valid high on the 3rd product: that product is dropped and the count restarts.
   - Required, after clear: products -1,-1,-1,-1 give out_sum=0xFFFFFC.
6. LEN=1:
   - Stimulus: products 0x8000, then 0x7FFF.
   - Required: results 0xFF8000 then 0x007FFF, each with out_valid 1 cycle after acceptance and one bubble between accepts.
